// File: rtl/bitpacker_pkg.sv
// Shared widths, types and field-length helpers for the bit packer.
package bitpacker_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned FILL_W = 5;
  localparam int unsigned ACC_W  = 63;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [FILL_W-1:0] fill_t;

  // Lengths above one word are treated as a full word.
  function automatic len_t sat_len(input len_t len);
    return (len > len_t'(WORD_W)) ? len_t'(WORD_W) : len;
  endfunction

  // Mask of the low 'len' bits; 'len' must already be saturated.
  function automatic word_t len_mask(input len_t len);
    if (len >= len_t'(WORD_W))
      return '1;
    else
      return (word_t'(1) << len[FILL_W-1:0]) - word_t'(1);
  endfunction

endpackage

// File: rtl/bitpacker_if.sv
// Field-in / word-out signal bundle of the bit packer.
interface bitpacker_if
  import bitpacker_pkg::*;
  ();

  logic  data_in_valid;
  word_t data_in;
  len_t  input_length;
  logic  data_out_valid;
  word_t data_out;

  modport master (
    output data_in_valid,
    output data_in,
    output input_length,
    input  data_out_valid,
    input  data_out
  );

  modport slave (
    input  data_in_valid,
    input  data_in,
    input  input_length,
    output data_out_valid,
    output data_out
  );

endinterface

// File: rtl/bitpacker.sv
// LSB-first packer: concatenates 0..32-bit fields into 32-bit words.
module bitpacker
  import bitpacker_pkg::*;
  (
    input logic        clock,
    input logic        nreset,
    bitpacker_if.slave bus
  );

  logic [ACC_W-1:0] acc;
  fill_t            fill;
  len_t             len_eff;
  word_t            masked;
  logic [ACC_W-1:0] merged;
  len_t             sum;

  // Merge the masked field above the pending bits; the sum never exceeds 63.
  always_comb begin
    len_eff = sat_len(bus.input_length);
    masked  = bus.data_in & len_mask(len_eff);
    merged  = acc | ({{(ACC_W-WORD_W){1'b0}}, masked} << fill);
    sum     = {1'b0, fill} + len_eff;
  end

  // Accumulator, fill count and registered word output.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc                <= '0;
      fill               <= '0;
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
    end else begin
      bus.data_out_valid <= 1'b0;
      if (bus.data_in_valid) begin
        // Low five bits of the sum equal sum-32 whenever a word completes.
        fill <= sum[FILL_W-1:0];
        if (sum[FILL_W]) begin
          bus.data_out       <= merged[WORD_W-1:0];
          bus.data_out_valid <= 1'b1;
          acc                <= merged >> WORD_W;
        end else begin
          acc <= merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitpacker.sv
// Directed and randomized self-checking bench for bitpacker.
module tb_bitpacker;
  import bitpacker_pkg::*;

  logic clock = 1'b0;
  logic nreset;
  int   errors = 0;
  int   checks = 0;

  bitpacker_if bus ();

  bitpacker dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input word_t ed);
    check({tag, ".valid"}, {31'b0, bus.data_out_valid}, {31'b0, ev});
    check({tag, ".data"}, bus.data_out, ed);
  endtask

  // One clock: drive at negedge, check #1 after the rising edge.
  task automatic step(input logic v, input word_t d, input int l,
                      input logic ev, input word_t ed, input string tag);
    @(negedge clock);
    bus.data_in_valid = v;
    bus.data_in       = d;
    bus.input_length  = len_t'(l);
    @(posedge clock);
    #1;
    check_out(tag, ev, ed);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.data_in_valid = 1'b0;
    nreset = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    nreset = 1'b1;
  endtask

  word_t            words [32];
  logic [1055:0]    stream;
  int               pos, fillm, widx, l, lf, s;
  word_t            m, d, last;

  initial begin
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    bus.input_length  = '0;
    nreset            = 1'b0;

    // Reset held
    repeat (3) @(posedge clock);
    #1;
    check_out("reset", 1'b0, 32'h0);
    @(negedge clock);
    nreset = 1'b1;
    step(1'b0, 32'hFFFF_FFFF, 32, 1'b0, 32'h0, "idle0");
    step(1'b0, 32'h1234_5678, 8,  1'b0, 32'h0, "idle1");

    // Four bytes, garbage above L ignored
    step(1'b1, 32'hFFFF_FF11, 8, 1'b0, 32'h0,         "byte0");
    step(1'b1, 32'h0000_0022, 8, 1'b0, 32'h0,         "byte1");
    step(1'b1, 32'h0000_0033, 8, 1'b0, 32'h0,         "byte2");
    step(1'b1, 32'h0000_AB44, 8, 1'b1, 32'h4433_2211, "byte3");
    step(1'b0, 32'h0,         0, 1'b0, 32'h4433_2211, "byte_hold");

    // Full words back to back
    step(1'b1, 32'hDEAD_BEEF, 32, 1'b1, 32'hDEAD_BEEF, "full0");
    step(1'b1, 32'h0123_4567, 32, 1'b1, 32'h0123_4567, "full1");
    step(1'b0, 32'h0,         32, 1'b0, 32'h0123_4567, "full_hold");

    // Straddling fields: 20+20 -> word, 8 bits (0xAB) left; +24 zeros -> word
    step(1'b1, 32'h0001_2345, 20, 1'b0, 32'h0123_4567, "strad0");
    step(1'b1, 32'h000A_BCDE, 20, 1'b1, 32'hCDE1_2345, "strad1");
    step(1'b1, 32'h0000_0000, 24, 1'b1, 32'h0000_00AB, "strad2");

    // Zero-length and idle cycles inside a partial word, then saturation
    step(1'b1, 32'hFFFF_5555, 16, 1'b0, 32'h0000_00AB, "zl0");
    step(1'b1, 32'hFFFF_FFFF, 0,  1'b0, 32'h0000_00AB, "zl1");
    step(1'b0, 32'hFFFF_FFFF, 32, 1'b0, 32'h0000_00AB, "zl2");
    step(1'b1, 32'h0000_0000, 0,  1'b0, 32'h0000_00AB, "zl3");
    step(1'b1, 32'h1234_AAAA, 16, 1'b1, 32'hAAAA_5555, "zl4");
    step(1'b1, 32'h89AB_CDEF, 40, 1'b1, 32'h89AB_CDEF, "sat40");
    step(1'b1, 32'h0F0F_0F0F, 63, 1'b1, 32'h0F0F_0F0F, "sat63");

    // Async reset mid-stream discards pending bits
    step(1'b1, 32'h0000_0FFF, 12, 1'b0, 32'h0F0F_0F0F, "pend");
    @(negedge clock);
    bus.data_in_valid = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 32'h0);
    @(negedge clock);
    nreset = 1'b1;
    step(1'b1, 32'h1357_9BDF, 32, 1'b1, 32'h1357_9BDF, "post_rst");

    // Random slicing of 32-word streams
    for (int iter = 0; iter < 200; iter++) begin
      do_reset();
      for (int w = 0; w < 32; w++) begin
        words[w] = $urandom;
        stream[w*32 +: 32] = words[w];
      end
      stream[1055:1024] = '0;
      pos = 0; fillm = 0; widx = 0; last = '0;
      while (pos < 1024) begin
        if ($urandom_range(0, 3) == 0) begin
          step(1'b0, $urandom, $urandom_range(0, 63), 1'b0, last, "rnd_gap");
        end else begin
          l = $urandom_range(0, 32);
          if (l > 1024 - pos) l = 1024 - pos;
          lf = (l == 32 && $urandom_range(0, 1) == 1) ? $urandom_range(33, 63) : l;
          m = (l >= 32) ? '1 : ((32'h1 << l) - 32'h1);
          d = ($urandom & ~m) | (stream[pos +: 32] & m);
          s = fillm + l;
          pos += l;
          if (s >= 32) begin
            fillm = s - 32;
            last = (widx < 32) ? words[widx] : 32'hX;
            widx++;
            step(1'b1, d, lf, 1'b1, last, "rnd_word");
          end else begin
            fillm = s;
            step(1'b1, d, lf, 1'b0, last, "rnd_part");
          end
        end
      end
      check("rnd_count", widx, 32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
